wlan_scrambler: RTL and testbench



---
 rtl/wlan_scrambler.sv | 94 +++++++++
 tb/tb_wlan_scrambler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wlan_scrambler.sv
// Bit-serial IEEE 802.11a transmit scrambler, polynomial x^7 + x^4 + 1.
// Loads a per-frame seed on start and scrambles bits with valid/ready on both sides.
module wlan_scrambler #(
  parameter logic [6:0]  DEFAULT_SEED = 7'b1011101,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:1]       seed_in,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             in_tail,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0] state;
  logic [7:1] lfsr;
  logic       seq;
  logic       in_fire;
  logic       out_fire;

  assign seq      = lfsr[7] ^ lfsr[4];
  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state != ST_IDLE) || out_valid;

  // An all-zero seed would lock the LFSR, so it is replaced by the default seed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      lfsr      <= '0;
      bit_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lfsr      <= (seed_in == 7'd0) ? DEFAULT_SEED : seed_in;
            bit_count <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (in_fire && in_last) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_fire && out_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (in_fire) begin
        lfsr <= {lfsr[6:1], seq};
        if (bit_count != {CNT_W{1'b1}}) begin
          bit_count <= bit_count + 1'b1;
        end
      end
    end
  end

  // Single-entry output register; it only reloads on an input handshake, so data holds while stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= in_tail ? 1'b0 : (in_data ^ seq);
        out_last  <= in_last;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wlan_scrambler.sv
// Self-checking bench for wlan_scrambler: hand-computed vector tables plus
// directed multi-cycle sequences (stalls, tail bits, drain, mid-frame reset).
module tb_wlan_scrambler;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic d;
    logic tail;
    logic last;
    logic exp_data;
    logic exp_last;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [7:1]       seed_in;
  logic             in_valid;
  logic             in_data;
  logic             in_tail;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_data;
  logic             out_last;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] bit_count;

  int   errors = 0;
  int   checks = 0;
  logic rand_ready = 1'b0;
  logic cap_data[$];
  logic cap_last[$];
  logic exp_q[$];
  logic [7:1] m_lfsr;
  logic prev_stall = 1'b0;
  logic prev_data;
  logic prev_last;
  vec_t vecs[23];

  always #5 clk = ~clk;

  wlan_scrambler #(.DEFAULT_SEED(7'b1011101), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .seed_in(seed_in),
    .in_valid(in_valid), .in_data(in_data), .in_tail(in_tail), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .bit_count(bit_count)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Output capture between edges: a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_output("stall_valid", out_valid, 1'b1);
        check_output("stall_data", out_data, prev_data);
        check_output("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        cap_data.push_back(out_data);
        cap_last.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_load(input logic [7:1] seed);
    m_lfsr = (seed == 7'd0) ? 7'b1011101 : seed;
  endtask

  task automatic clear_queues();
    cap_data.delete();
    cap_last.delete();
    exp_q.delete();
  endtask

  task automatic apply_stimulus(input logic d, input logic tail, input logic last);
    int   waited = 0;
    logic s;
    in_valid = 1'b1;
    in_data  = d;
    in_tail  = tail;
    in_last  = last;
    #1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check_output("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      s = m_lfsr[7] ^ m_lfsr[4];
      exp_q.push_back(tail ? 1'b0 : (d ^ s));
      m_lfsr = {m_lfsr[6:1], s};
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [7:1] seed);
    start   = 1'b1;
    seed_in = seed;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int w = 0;
    #3;
    while (cap_data.size() < n && w < 2000) begin
      @(negedge clk);
      #3;
      w++;
    end
    check_output("output_count", cap_data.size(), n);
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 500) begin
      @(negedge clk);
      #3;
      w++;
    end
    check_output("idle_reached", busy, 1'b0);
    @(negedge clk);
  endtask

  task automatic compare_model(input string name);
    int bad = 0;
    check_output({name, "_len"}, cap_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_data.size(); i++) begin
      if (cap_data[i] !== exp_q[i]) bad++;
    end
    check_output({name, "_bad_bits"}, bad, 0);
  endtask

  // Runs a frame from the vector table; optionally pulses start mid-frame (must be ignored).
  task automatic run_table(input logic [7:1] seed, input int base, input int n, input int mid_start);
    clear_queues();
    model_load(seed);
    start    = 1'b1;
    seed_in  = seed;
    in_valid = 1'b1;
    in_data  = 1'b1;
    #1;
    check_output("idle_in_ready", in_ready, 1'b0);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == mid_start) begin
        in_valid = 1'b0;
        pulse_start(7'd0);
      end
      apply_stimulus(vecs[base+i].d, vecs[base+i].tail, vecs[base+i].last);
    end
    in_valid = 1'b0;
    check_output($sformatf("bit_count_%0d", base), bit_count, n);
    wait_outputs(n);
    check_output($sformatf("busy_before_drop_%0d", base), busy, 1'b1);
    for (int i = 0; i < n && i < cap_data.size(); i++) begin
      check_output($sformatf("vec%0d_data", base + i), cap_data[i], vecs[base+i].exp_data);
      check_output($sformatf("vec%0d_last", base + i), cap_last[i], vecs[base+i].exp_last);
    end
    @(negedge clk);
    #3;
    check_output($sformatf("busy_drop_%0d", base), busy, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] pat_a;
    logic [6:0]  pat_b;
    int          ones;
    int          bad;
    int          last_cnt;
    int          last_idx;

    pat_a = 16'b0000111011110010;
    pat_b = 7'b0110110;
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{d: 1'b0, tail: 1'b0, last: (i == 15), exp_data: pat_a[15-i], exp_last: (i == 15)};
    end
    for (int i = 0; i < 7; i++) begin
      vecs[16+i] = '{d: 1'b0, tail: 1'b0, last: (i == 6), exp_data: pat_b[6-i], exp_last: (i == 6)};
    end

    reset     = 1'b0;
    start     = 1'b0;
    seed_in   = 7'd0;
    in_valid  = 1'b0;
    in_data   = 1'b0;
    in_tail   = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_output("reset_in_ready", in_ready, 1'b0);
    check_output("reset_out_valid", out_valid, 1'b0);
    check_output("reset_out_data", out_data, 1'b0);
    check_output("reset_out_last", out_last, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_bit_count", bit_count, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] seed 7F, 16 zero bits");
    run_table(7'h7F, 0, 16, -1);

    $display("[TB] zero seed falls back to default seed");
    run_table(7'd0, 16, 7, -1);

    $display("[TB] period 127");
    clear_queues();
    model_load(7'h7F);
    pulse_start(7'h7F);
    for (int i = 0; i < 254; i++) apply_stimulus(1'b0, 1'b0, (i == 253));
    in_valid = 1'b0;
    wait_outputs(254);
    wait_idle();
    compare_model("period_model");
    if (cap_data.size() == 254) begin
      ones = 0;
      bad  = 0;
      for (int i = 0; i < 127; i++) begin
        if (cap_data[i] === 1'b1) ones++;
        if (cap_data[i] !== cap_data[i+127]) bad++;
      end
      check_output("period_ones", ones, 64);
      check_output("period_repeat_bad_bits", bad, 0);
    end

    $display("[TB] random backpressure and data");
    clear_queues();
    rand_ready = 1'b1;
    seed_in    = 7'($urandom_range(1, 127));
    model_load(seed_in);
    pulse_start(seed_in);
    for (int i = 0; i < 80; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), (i == 79));
    end
    in_valid = 1'b0;
    wait_outputs(80);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_idle();
    compare_model("random");

    $display("[TB] tail bits and start during drain");
    clear_queues();
    model_load(7'h7F);
    pulse_start(7'h7F);
    for (int i = 0; i < 24; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b1, (i == 5));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("tail_bit_count", bit_count, 30);
    pulse_start(7'h01);
    #1;
    check_output("drain_in_ready", in_ready, 1'b0);
    check_output("drain_busy", busy, 1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    wait_outputs(30);
    @(negedge clk);
    #3;
    check_output("drain_start_ignored", busy, 1'b0);
    @(negedge clk);
    compare_model("tail_model");
    if (cap_data.size() == 30) begin
      bad      = 0;
      last_cnt = 0;
      last_idx = -1;
      for (int i = 24; i < 30; i++) if (cap_data[i] !== 1'b0) bad++;
      for (int i = 0; i < 30; i++) begin
        if (cap_last[i] === 1'b1) begin
          last_cnt++;
          last_idx = i;
        end
      end
      check_output("tail_zero_bad_bits", bad, 0);
      check_output("tail_last_count", last_cnt, 1);
      check_output("tail_last_index", last_idx, 29);
    end

    $display("[TB] reset mid-frame, then start during run");
    clear_queues();
    model_load(7'h7F);
    pulse_start(7'h7F);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 1) out_ready = 1'b1;
      apply_stimulus(1'b1, 1'b0, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b0;
    #3;
    check_output("midreset_out_valid", out_valid, 1'b0);
    check_output("midreset_busy", busy, 1'b0);
    check_output("midreset_bit_count", bit_count, 0);
    @(negedge clk);
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    run_table(7'h7F, 0, 16, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
